// File: rtl/trig_shaper_if.sv
// Trigger shaper signal bundle: detector input, arming/clear controls, shaped trigger and status outputs.
// The DUT attaches through the slave modport and the driver through the master modport.
interface trig_shaper_if #(
  parameter int CNT_W = 16
);
  logic             sig_in;
  logic             enable;
  logic             clr_cnt;
  logic             trig;
  logic             busy;
  logic [CNT_W-1:0] evt_cnt;

  modport slave (
    input  sig_in, enable, clr_cnt,
    output trig, busy, evt_cnt
  );

  modport master (
    output sig_in, enable, clr_cnt,
    input  trig, busy, evt_cnt
  );
endinterface

// File: rtl/trig_shaper.sv
// Trigger shaper: synchronizes sig_in, filters short pulses, emits one trig per edge, then enforces dead time.
// The event counter and clr_cnt exist only when TRIG_EVTCNT_EN is defined; otherwise evt_cnt is tied to 0.
module trig_shaper #(
  parameter int FILT_LEN = 2,
  parameter int HOLDOFF  = 100,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  trig_shaper_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILTER   = 3'd1,
    FIRE     = 3'd2,
    HOLD     = 3'd3,
    WAIT_LOW = 3'd4
  } state_t;

  localparam logic [7:0]  FLEN = 8'(FILT_LEN);
  localparam logic [15:0] HLEN = 16'(HOLDOFF);

  state_t      state_q, state_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic        sync1_q, sync_q;
  logic        trig_q, busy_q;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable && sync_q) begin
          if (FILT_LEN == 1) begin
            state_d = FIRE;
          end else begin
            state_d = FILTER;
            fcnt_d  = 8'd1;
          end
        end
      end
      FILTER: begin
        if (!sync_q || !bus.enable) begin
          state_d = IDLE;
          fcnt_d  = 8'd0;
        end else begin
          fcnt_d = fcnt_q + 8'd1;
          if (fcnt_q + 8'd1 == FLEN) state_d = FIRE;
        end
      end
      FIRE: begin
        state_d = HOLD;
        hcnt_d  = 16'd0;
      end
      // Dead time: input level is deliberately not looked at here.
      HOLD: begin
        hcnt_d = hcnt_q + 16'd1;
        if (hcnt_q + 16'd1 == HLEN) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= 8'd0;
      hcnt_q  <= 16'd0;
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      hcnt_q  <= hcnt_d;
      sync1_q <= bus.sig_in;
      sync_q  <= sync1_q;
      trig_q  <= (state_d == FIRE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.trig = trig_q;
  assign bus.busy = busy_q;

`ifdef TRIG_EVTCNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] evt_q, evt_d;

  // A clear coinciding with FIRE still counts the trigger that is firing.
  always_comb begin
    evt_d = evt_q;
    if (bus.clr_cnt) evt_d = '0;
    if (state_q == FIRE) begin
      if (bus.clr_cnt)      evt_d = CNT_ONE;
      else if (evt_q != '1) evt_d = evt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) evt_q <= '0;
    else     evt_q <= evt_d;
  end

  assign bus.evt_cnt = evt_q;
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = bus.clr_cnt;
  assign bus.evt_cnt    = '0;
`endif

endmodule

// File: tb/tb_trig_shaper.sv
// Scoreboard bench for trig_shaper: stimulus pushes expected trig cycles, per-DUT monitors pop and compare.
module tb_trig_shaper;

`ifdef TRIG_EVTCNT_EN
  localparam int EVT_EN = 1;
`else
  localparam int EVT_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   qa[$];
  int   qb[$];
  int   ea, eb;
  logic ta_prev = 1'b0;
  logic tb_prev = 1'b0;

  trig_shaper_if #(.CNT_W(16)) ifa ();
  trig_shaper_if #(.CNT_W(3))  ifb ();

  trig_shaper #(.FILT_LEN(2), .HOLDOFF(100), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  trig_shaper #(.FILT_LEN(1), .HOLDOFF(2), .CNT_W(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int expc(input int n);
    return (EVT_EN != 0) ? n : 0;
  endfunction

  function automatic int expb(input int n);
    return (EVT_EN != 0) ? ((n > 7) ? 7 : n) : 0;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_a(input int len);
    ifa.sig_in = 1'b1;
    step(len);
    ifa.sig_in = 1'b0;
  endtask

  task automatic pulse_b(input int len);
    ifb.sig_in = 1'b1;
    step(len);
    ifb.sig_in = 1'b0;
  endtask

  always @(negedge clk) begin
    if (ifa.trig === 1'b1) begin
      chk("trig_a_single_cycle", ta_prev, 0);
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL trig_a_unexpected: got trig=1, expected none (cycle %0d)", cyc);
      end else begin
        ea = qa.pop_front();
        chk("trig_a_cycle", cyc, ea);
      end
    end
    ta_prev = ifa.trig;
  end

  always @(negedge clk) begin
    if (ifb.trig === 1'b1) begin
      chk("trig_b_single_cycle", tb_prev, 0);
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL trig_b_unexpected: got trig=1, expected none (cycle %0d)", cyc);
      end else begin
        eb = qb.pop_front();
        chk("trig_b_cycle", cyc, eb);
      end
    end
    tb_prev = ifb.trig;
  end

  initial begin
    int k;
    ifa.sig_in = 1'b0; ifa.enable = 1'b1; ifa.clr_cnt = 1'b0;
    ifb.sig_in = 1'b0; ifb.enable = 1'b1; ifb.clr_cnt = 1'b0;

    // Reset held with a toggling input
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ifa.sig_in = ~ifa.sig_in;
      ifb.sig_in = ~ifb.sig_in;
      chk("rst_trig", ifa.trig, 0);
      chk("rst_busy", ifa.busy, 0);
      chk("rst_evt", ifa.evt_cnt, 0);
    end
    ifa.sig_in = 1'b0;
    ifb.sig_in = 1'b0;
    step(1);
    rst = 1'b0;
    step(4);
    chk("post_rst_busy", ifa.busy, 0);

    // Glitch shorter than the filter
    pulse_a(1);
    chk("glitch_busy_k1", ifa.busy, 0);
    step(1); chk("glitch_busy_k2", ifa.busy, 0);
    step(1); chk("glitch_busy_k3", ifa.busy, 1);
    step(1); chk("glitch_busy_k4", ifa.busy, 0);
    step(5); chk("glitch_evt", ifa.evt_cnt, 0);

    // Accepted pulse
    k = cyc; qa.push_back(k + 4);
    pulse_a(5);
    step(120);
    chk("accept_evt", ifa.evt_cnt, expc(1));
    chk("accept_busy_idle", ifa.busy, 0);

    // Second pulse inside dead time is ignored, third is accepted
    k = cyc; qa.push_back(k + 4);
    pulse_a(5);
    step(49);
    pulse_a(5);
    step(20);
    chk("holdoff_busy", ifa.busy, 1);
    step(125);
    k = cyc; qa.push_back(k + 4);
    pulse_a(5);
    step(120);
    chk("holdoff_evt", ifa.evt_cnt, expc(3));

    // Long level gives one trig; low then high gives another
    k = cyc; qa.push_back(k + 4);
    ifa.sig_in = 1'b1;
    step(500);
    chk("level_wait_low_busy", ifa.busy, 1);
    ifa.sig_in = 1'b0;
    step(5);
    k = cyc; qa.push_back(k + 4);
    pulse_a(5);
    step(120);
    chk("level_evt", ifa.evt_cnt, expc(5));

    // enable low aborts FILTER
    ifa.sig_in = 1'b1;
    step(3);
    chk("abort_filter_busy", ifa.busy, 1);
    ifa.enable = 1'b0;
    step(1);
    chk("abort_idle_busy", ifa.busy, 0);
    step(2);
    ifa.sig_in = 1'b0;
    step(5);
    ifa.enable = 1'b1;
    step(2);
    chk("abort_evt", ifa.evt_cnt, expc(5));

    // enable low does not cut HOLDOFF short
    k = cyc; qa.push_back(k + 4);
    pulse_a(5);
    ifa.enable = 1'b0;
    step(40);
    chk("en_low_holdoff_busy", ifa.busy, 1);
    step(80);
    chk("en_low_done_busy", ifa.busy, 0);
    ifa.enable = 1'b1;
    chk("en_low_evt", ifa.evt_cnt, expc(6));

    // clr_cnt coincident with FIRE
    k = cyc; qa.push_back(k + 4);
    ifa.sig_in = 1'b1;
    step(4);
    ifa.clr_cnt = 1'b1;
    step(1);
    ifa.clr_cnt = 1'b0;
    ifa.sig_in  = 1'b0;
    chk("clr_fire_evt", ifa.evt_cnt, expc(1));
    step(120);
    ifa.clr_cnt = 1'b1;
    step(1);
    ifa.clr_cnt = 1'b0;
    chk("clr_evt", ifa.evt_cnt, 0);

    // Reset mid-FILTER
    ifa.sig_in = 1'b1;
    step(3);
    chk("rst_filter_busy_pre", ifa.busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_filter_busy", ifa.busy, 0);
    ifa.sig_in = 1'b0;
    step(3);
    rst = 1'b0;
    step(10);

    // Reset mid-FIRE
    k = cyc; qa.push_back(k + 4);
    ifa.sig_in = 1'b1;
    step(4);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_fire_trig", ifa.trig, 0);
    chk("rst_fire_busy", ifa.busy, 0);
    ifa.sig_in = 1'b0;
    step(3);
    rst = 1'b0;
    step(10);

    // Reset mid-HOLDOFF, released with input high
    k = cyc; qa.push_back(k + 4);
    pulse_a(5);
    step(20);
    chk("rst_hold_busy_pre", ifa.busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_hold_busy", ifa.busy, 0);
    chk("rst_hold_evt", ifa.evt_cnt, 0);
    ifa.sig_in = 1'b1;
    step(3);
    rst = 1'b0;
    k = cyc; qa.push_back(k + 4);
    step(10);
    ifa.sig_in = 1'b0;
    step(120);
    chk("rst_release_high_evt", ifa.evt_cnt, expc(1));

    // Narrow counter saturates, FILT_LEN=1 latency
    for (int i = 1; i <= 9; i++) begin
      k = cyc; qb.push_back(k + 3);
      pulse_b(2);
      step(8);
      chk("sat_evt_b", ifb.evt_cnt, expb(i));
    end

    step(5);
    chk("trig_a_all_seen", qa.size(), 0);
    chk("trig_b_all_seen", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trig_shaper.md
TRIG_SHAPER -- requirements
Module: trig_shaper

Interface
REQ-001 Parameter FILT_LEN, default 2: consecutive synchronized-high cycles required to accept an input edge; legal range 1..255.
REQ-002 Parameter HOLDOFF, default 100: dead-time cycles after each accepted trigger; legal range 1..65535.
REQ-003 Parameter CNT_W, default 16: width of the event counter.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Port clk  input  1: the single clock; all state changes occur on its rising edge.
REQ-006 Port rst  input  1: asynchronous, active-high reset.
REQ-007 Port sig_in  input  1: asynchronous detector/discriminator signal.
REQ-008 Port enable  input  1: arms edge acceptance when high.
REQ-009 Port clr_cnt  input  1: synchronous event-counter clear.
REQ-010 Port trig  output  1: one-cycle registered pulse; feeds the led block's trig input.
REQ-011 Port busy  output  1: high whenever the FSM is not in IDLE.
REQ-012 Port evt_cnt  output  CNT_W: count of accepted triggers.

Function
REQ-013 sig_in SHALL pass through a 2-flop synchronizer; the FSM sees only the second flop, sync.
REQ-014 The FSM SHALL have states IDLE, FILTER, FIRE, HOLDOFF and WAIT_LOW.
REQ-015 IDLE: on enable=1 and sync=1, go to FIRE if FILT_LEN=1, else go to FILTER with fcnt=1; otherwise stay.
REQ-016 FILTER: on sync=0 or enable=0, return to IDLE; else increment fcnt, and when fcnt+1 = FILT_LEN go to FIRE.
REQ-017 FIRE: lasts exactly one cycle; trig=1; evt_cnt updates; next state HOLDOFF with hcnt=0.
REQ-018 HOLDOFF: increment hcnt; after HOLDOFF cycles in this state go to WAIT_LOW; sync is ignored.
REQ-019 WAIT_LOW: on sync=0 go to IDLE; a level held high SHALL never produce a second trig.
REQ-020 trig SHALL equal (state==FIRE), registered, and is never high for two consecutive cycles.
REQ-021 Latency: if sig_in is first sampled high at edge N and stays high, trig SHALL be high in the cycle following edge N+1+FILT_LEN.
REQ-022 An input pulse shorter than FILT_LEN synchronized cycles SHALL produce no trig.
REQ-023 enable=0 SHALL abort FILTER only; FIRE, HOLDOFF and WAIT_LOW SHALL complete normally.
REQ-024 evt_cnt SHALL increment by 1 on FIRE and saturate at all-ones (no wrap).
REQ-025 clr_cnt=1 SHALL set evt_cnt to 0 on the next edge; if clr_cnt and FIRE coincide, evt_cnt SHALL become 1.
REQ-026 busy SHALL equal (state != IDLE), registered.

Reset
REQ-027 rst=1 SHALL immediately force the following, independent of clk: state=IDLE, both synchronizer flops=0, fcnt=0, hcnt=0, trig=0, busy=0, evt_cnt=0.
REQ-028 Reset asserted mid-FILTER, mid-FIRE or mid-HOLDOFF SHALL drop trig and busy at once; no pending trig SHALL be emitted after release.
REQ-029 After rst deasserts, the first trig SHALL require sync=0 then 1 only if sync was low at release; a high sync at release SHALL be treated as a new edge.

Configuration
REQ-030 Macro TRIG_EVTCNT_EN, when defined, SHALL include the evt_cnt counter and the clr_cnt logic.
REQ-031 When TRIG_EVTCNT_EN is undefined, evt_cnt SHALL be tied to 0 and clr_cnt ignored; the port list is unchanged and trig/busy timing is identical.

Verification
REQ-032 Reset: assert rst 3 cycles with sig_in toggling -> trig=0, busy=0, evt_cnt=0 throughout.
REQ-033 Glitch: FILT_LEN=2, sig_in high 1 cycle -> no trig, evt_cnt=0, busy=1 for 1 cycle then 0.
REQ-034 Accept: sig_in high 5 cycles from edge N -> one trig in the cycle after edge N+3, evt_cnt=1.
REQ-035 Holdoff: HOLDOFF=100, second pulse 50 cycles after trig -> ignored; third pulse 200 cycles after -> trig, evt_cnt=2.
REQ-036 Level: sig_in held high 500 cycles -> exactly one trig; a low then high again -> second trig.
REQ-037 Counter: preload to 16'hFFFF, one more trig -> stays FFFF; clr_cnt coincident with FIRE -> evt_cnt=1; rst mid-HOLDOFF -> busy=0 immediately.
